// File: rtl/rr_arb_32.sv
// Round-robin arbiter for 32 requesters sharing one 32:1 mux.
// Registers a one-hot grant and a 5-bit select, held until done, request drop or hold timeout.
module rr_arb_32 #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req,
    input  logic        done,
    output logic [31:0] gnt,
    output logic        gnt_vld,
    output logic [4:0]  sel,
    output logic        timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam int unsigned HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LAST_I);

    state_t            state;
    logic [4:0]        ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic        req_cur;
    logic        at_limit;
    logic        rel;
    logic        rel_tmo;
    logic        arb_hit;
    logic [4:0]  arb_ptr;
    logic [4:0]  off;
    logic [4:0]  win;
    logic [63:0] dbl;
    logic [31:0] rot;

    always_comb begin
        req_cur  = req[sel];
        at_limit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
        rel      = done | ~req_cur | at_limit;
        rel_tmo  = at_limit & ~done & req_cur;
        // On release the pointer moves past the current owner before this edge's arbitration.
        arb_ptr  = (state == BUSY) ? sel + 5'd1 : ptr;
        dbl      = {req, req} >> arb_ptr;
        rot      = dbl[31:0];
        arb_hit  = |req;
        off      = '0;
        for (int unsigned i = 32; i > 0; i--) begin
            if (rot[i-1]) off = 5'(i - 1);
        end
        win      = arb_ptr + off;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_vld  <= 1'b0;
            sel      <= '0;
            timeout  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_hit) begin
                        gnt      <= 32'd1 << win;
                        sel      <= win;
                        gnt_vld  <= 1'b1;
                        hold_cnt <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (rel) begin
                        ptr     <= arb_ptr;
                        timeout <= rel_tmo;
                        if (arb_hit) begin
                            gnt      <= 32'd1 << win;
                            sel      <= win;
                            hold_cnt <= '0;
                        end else begin
                            gnt     <= '0;
                            gnt_vld <= 1'b0;
                            state   <= IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
